// File: rtl/sm_axil_regfile.sv
// AXI4-Lite slave exposing four 32-bit registers to the security monitor core.
// Independent AW/W holding registers; one outstanding write and one outstanding read.
module sm_axil_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_q,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_q,
  output logic [3:0]                      wr_pulse
);

  localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned NREG = 4;
  localparam int unsigned IW   = 2;

  logic                     addr_hold_v_q, addr_hold_v_d;
  logic [IW-1:0]            addr_idx_q, addr_idx_d;
  logic                     data_hold_v_q, data_hold_v_d;
  logic [DW-1:0]            data_hold_q, data_hold_d;
  logic [SW-1:0]            strb_hold_q, strb_hold_d;
  logic                     bvalid_q, bvalid_d;
  logic [NREG-1:0]          wr_pulse_d;
  logic                     rvalid_q, rvalid_d;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic [NREG-1:0][DW-1:0]  regs_q, regs_d;
  logic                     aw_hs, w_hs, ar_hs, commit;
  logic                     unused_bits;

  // Readies are gated by reset so nothing handshakes while the block is held in reset.
  assign S_AXI_AWREADY = S_AXI_ARESETN & S_AXI_AWVALID & ~addr_hold_v_q & ~bvalid_q;
  assign S_AXI_WREADY  = S_AXI_ARESETN & S_AXI_WVALID  & ~data_hold_v_q & ~bvalid_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = addr_hold_v_q & data_hold_v_q;

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = 2'b00;

  assign reg0_q = regs_q[0];
  assign reg1_q = regs_q[1];
  assign reg2_q = regs_q[2];
  assign reg3_q = regs_q[3];

  // Protection bits and byte-offset address bits carry no meaning here.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Next-state logic for holds, commit, write response and read response.
  always_comb begin
    addr_hold_v_d = addr_hold_v_q;
    addr_idx_d    = addr_idx_q;
    data_hold_v_d = data_hold_v_q;
    data_hold_d   = data_hold_q;
    strb_hold_d   = strb_hold_q;
    bvalid_d      = bvalid_q;
    wr_pulse_d    = '0;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    regs_d        = regs_q;

    if (aw_hs) begin
      addr_hold_v_d = 1'b1;
      addr_idx_d    = S_AXI_AWADDR[3:2];
    end
    if (w_hs) begin
      data_hold_v_d = 1'b1;
      data_hold_d   = S_AXI_WDATA;
      strb_hold_d   = S_AXI_WSTRB;
    end

    if (commit) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (strb_hold_q[b]) begin
          regs_d[addr_idx_q][8*b +: 8] = data_hold_q[8*b +: 8];
        end
      end
      wr_pulse_d    = NREG'(1) << addr_idx_q;
      bvalid_d      = 1'b1;
      addr_hold_v_d = 1'b0;
      data_hold_v_d = 1'b0;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read samples the current register value, so a same-edge commit is not visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      addr_hold_v_q <= 1'b0;
      addr_idx_q    <= '0;
      data_hold_v_q <= 1'b0;
      data_hold_q   <= '0;
      strb_hold_q   <= '0;
      bvalid_q      <= 1'b0;
      wr_pulse      <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      regs_q        <= '0;
    end else begin
      addr_hold_v_q <= addr_hold_v_d;
      addr_idx_q    <= addr_idx_d;
      data_hold_v_q <= data_hold_v_d;
      data_hold_q   <= data_hold_d;
      strb_hold_q   <= strb_hold_d;
      bvalid_q      <= bvalid_d;
      wr_pulse      <= wr_pulse_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      regs_q        <= regs_d;
    end
  end

endmodule

// File: tb/tb_sm_axil_regfile.sv
// Self-checking bench for sm_axil_regfile: scoreboard queues for write strobes
// and read data, filled at stimulus time and drained by a negedge monitor.
module tb_sm_axil_regfile;

  typedef struct packed {
    logic [3:0]  pulse;
    logic [1:0]  idx;
    logic [31:0] val;
  } wp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_q, reg1_q, reg2_q, reg3_q;
  logic [3:0]  wr_pulse;

  int          n_cmp;
  int          n_err;
  logic [31:0] mdl [4];
  wp_t         wp_q [$];
  logic [31:0] rd_q [$];
  wp_t         mon_e;
  logic [31:0] mon_rd;
  logic [31:0] old_val;

  sm_axil_regfile dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_q        (reg0_q),
    .reg1_q        (reg1_q),
    .reg2_q        (reg2_q),
    .reg3_q        (reg3_q),
    .wr_pulse      (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_sel(input logic [1:0] i);
    case (i)
      2'd0:    return reg0_q;
      2'd1:    return reg1_q;
      2'd2:    return reg2_q;
      default: return reg3_q;
    endcase
  endfunction

  // Drain scoreboards whenever the DUT produces a write strobe or read beat.
  always @(negedge clk) begin
    if (wr_pulse != 4'b0000) begin
      if (wp_q.size() == 0) begin
        chk("wp_unexpected", 32'(wp_q.size()), 32'd1);
      end else begin
        mon_e = wp_q.pop_front();
        chk("wr_pulse", 32'(wr_pulse), 32'(mon_e.pulse));
        chk("reg_q_at_pulse", reg_sel(mon_e.idx), mon_e.val);
      end
    end
    if (rvalid && rready) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(rd_q.size()), 32'd1);
      end else begin
        mon_rd = rd_q.pop_front();
        chk("rdata", rdata, mon_rd);
        chk("rresp", 32'(rresp), 32'd0);
      end
    end
    if (bvalid && bready) chk("bresp", 32'(bresp), 32'd0);
  end

  task automatic chk_reset_state();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready",  32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid",  32'(bvalid), 0);
    chk("rst_rvalid",  32'(rvalid), 0);
    chk("rst_wr_pulse", 32'(wr_pulse), 0);
    chk("rst_bresp",   32'(bresp), 0);
    chk("rst_rresp",   32'(rresp), 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_reg0", reg0_q, 0);
    chk("rst_reg1", reg1_q, 0);
    chk("rst_reg2", reg2_q, 0);
    chk("rst_reg3", reg3_q, 0);
  endtask

  task automatic wr_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wp_t e;
    for (int b = 0; b < 4; b++) if (s[b]) mdl[a[3:2]][8*b +: 8] = d[8*b +: 8];
    e.pulse = 4'b0001 << a[3:2];
    e.idx   = a[3:2];
    e.val   = mdl[a[3:2]];
    wp_q.push_back(e);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
  endtask

  task automatic wr_hs();
    int   n = 0;
    logic aw_d = 1'b0, w_d = 1'b0, aw_h, w_h;
    while (!(aw_d && w_d) && n < 40) begin
      @(negedge clk);
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_h) begin aw_d = 1'b1; awvalid = 1'b0; end
      if (w_h)  begin w_d  = 1'b1; wvalid  = 1'b0; end
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_hs", 32'({aw_d, w_d}), 32'h3);
  endtask

  // Entered just after the AW/W handshake edge; BVALID must show two cycles later.
  task automatic wr_resp();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    chk("wr_latency", 32'(n), 32'd2);
  endtask

  // Entered at a negedge; completes the B handshake.
  task automatic b_ack();
    int n = 0;
    while (!(bvalid && bready) && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("b_hs", 32'(bvalid && bready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_start(a, d, s);
    wr_hs();
    wr_resp();
    b_ack();
  endtask

  task automatic rd_start(input logic [3:0] a);
    rd_q.push_back(mdl[a[3:2]]);
    araddr  = a;
    arvalid = 1'b1;
  endtask

  task automatic rd_hs();
    int   n = 0;
    logic done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      done = arvalid && arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    chk("ar_hs", 32'(done), 32'd1);
  endtask

  task automatic rd_data();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 20);
    chk("rd_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic read(input logic [3:0] a);
    rd_start(a);
    rd_hs();
    rd_data();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1; araddr = '0; arprot = '0; arvalid = 0; rready = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    awvalid = 1; wvalid = 1; arvalid = 1;
    #1 chk_reset_state();
    repeat (2) @(posedge clk);
    #1 awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Four full writes with AW/W together, then read them back.
    for (int i = 0; i < 4; i++) write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) read(4'(i * 4));

    // Partial byte strobes.
    write(4'h4, 32'hFFFF_FFFF, 4'hF);
    write(4'h4, 32'h1234_5678, 4'b0101);
    read(4'h4);
    chk("strb_reg1", reg1_q, 32'hFF34_FF78);

    // Zero strobe still completes without changing contents.
    write(4'h0, 32'hDEAD_0000, 4'b0000);
    read(4'h0);

    // AW three cycles ahead of W.
    wr_start(4'h8, 32'hA5A5_A5A5, 4'hF);
    wvalid = 1'b0;
    @(negedge clk); chk("aw_early_ready", 32'(awready), 1);
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); chk("aw_hold_blocks", 32'(awready), 0);
    repeat (2) @(posedge clk);
    #1 wvalid = 1'b1;
    @(negedge clk); chk("w_late_ready", 32'(wready), 1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk); chk("b_after_w_1", 32'(bvalid), 0);
    @(negedge clk); chk("b_after_w_2", 32'(bvalid), 1);
    chk("reg2_late_w", reg2_q, 32'hA5A5_A5A5);
    b_ack();

    // Address bits [1:0] ignored on both write and read.
    write(4'hB, 32'h0000_003C, 4'b0001);
    read(4'h9);

    // Read landing on the commit edge of a write to the same register sees the old value.
    old_val = mdl[3];
    wr_start(4'hC, 32'h0BAD_F00D, 4'hF);
    wr_hs();
    araddr = 4'hC; arvalid = 1'b1; rd_q.push_back(old_val);
    @(negedge clk); chk("rw_arready", 32'(arready), 1); chk("rw_bvalid_pre", 32'(bvalid), 0);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk); chk("rw_bvalid", 32'(bvalid), 1); chk("rw_rvalid", 32'(rvalid), 1);
    b_ack();
    read(4'hC);

    // BREADY held low with a second write waiting.
    bready = 1'b0;
    wr_start(4'h0, 32'h1111_1111, 4'hF);
    wr_hs();
    wr_resp();
    @(posedge clk); #1;
    wr_start(4'h4, 32'h2222_2222, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 1);
      chk("bp_awready", 32'(awready), 0);
      chk("bp_wready", 32'(wready), 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    b_ack();
    wr_hs();
    wr_resp();
    b_ack();
    read(4'h0);
    read(4'h4);

    // RREADY held low with a second AR waiting.
    write(4'hC, 32'hDEAD_BEEF, 4'hF);
    rready = 1'b0;
    rd_start(4'hC);
    rd_hs();
    rd_start(4'hC);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rp_rvalid", 32'(rvalid), 1);
      chk("rp_rdata", rdata, 32'hDEAD_BEEF);
      chk("rp_arready", 32'(arready), 0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    rd_hs();
    rd_data();

    // Reset between the AW and W handshakes.
    awaddr = 4'h0; awvalid = 1'b1;
    @(negedge clk); chk("mid_aw_ready", 32'(awready), 1);
    @(posedge clk); #1 awvalid = 1'b0;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_state();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (3) begin
      @(negedge clk); chk("rst_no_pulse", 32'(wr_pulse), 0);
    end
    @(posedge clk); #1 wvalid = 1'b0; rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); chk("post_rst_no_pulse", 32'(wr_pulse), 0);
    end
    @(posedge clk); #1;
    read(4'h0);
    read(4'hC);

    repeat (3) @(posedge clk);
    chk("wp_q_drained", 32'(wp_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_axil_regfile.md
SM_AXIL_REGFILE -- requirements
Module: sm_axil_regfile

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; covers four 32-bit registers.
REQ-003 S_AXI_ACLK  input  1  sole clock; all logic is on the rising edge.
REQ-004 S_AXI_ARESETN  input  1  reset, asynchronous and active-low.
REQ-005 S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored.
REQ-006 S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
REQ-007 S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
REQ-008 S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  4/3/1/1  read address channel; ARPROT is ignored.
REQ-009 S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
REQ-010 reg0_q..reg3_q  output  32 each  current register contents, driven to the security monitor core.
REQ-011 wr_pulse  output  4  one-cycle strobe; bit n fires for a completed write to register n.

Function
REQ-012 Decode uses address bits [3:2] only; bits [1:0] are ignored.
REQ-013 The AW and W channels are accepted independently, each into a one-entry holding register (addr_hold_v, data_hold_v).
- AWREADY=1 for one cycle when AWVALID=1, addr_hold_v=0 and BVALID=0.
- WREADY follows the same rule using WVALID and data_hold_v.
REQ-014 The write commits in the cycle after both holds are valid:
- Selected register bytes are updated per WSTRB.
- The matching wr_pulse bit is 1 for exactly one cycle.
- BVALID is set to 1 and BRESP to 2'b00.
- Both holds are cleared.
REQ-015 AW and W arriving in the same cycle commit on the next edge: two-cycle write latency from the VALID/READY cycle to BVALID.
REQ-016 BVALID stays 1 until a cycle with BREADY=1. While BVALID=1, no new AW or W is accepted (one outstanding write).
REQ-017 A write with WSTRB=4'b0000 still completes:
- BVALID is returned and wr_pulse fires.
- Register contents are unchanged.
REQ-018 Read: ARREADY=1 for one cycle when ARVALID=1, RVALID=0 and no read is in flight. In the next cycle RVALID=1, RDATA=selected register, RRESP=2'b00.
REQ-019 RVALID and RDATA stay stable until a cycle with RREADY=1; no new AR is accepted until then.
REQ-020 Read and write paths are independent and may proceed in the same cycle.
REQ-021 A read and a committing write to the same register in the same cycle: the read returns the pre-write value.
REQ-022 Responses are never SLVERR or DECERR; every address maps to a register.
REQ-023 reg0_q..reg3_q are registered outputs that reflect a write in the cycle wr_pulse is asserted.

Reset
REQ-024 While S_AXI_ARESETN=0, the following are 0:
- AWREADY, WREADY, BVALID, ARREADY, RVALID, wr_pulse.
- BRESP, RRESP, RDATA.
- All holds and in-flight flags.
- reg0_q..reg3_q.
REQ-025 Reset asserted mid-transaction discards held AW/W data and pending responses; no wr_pulse is generated.
REQ-026 After deassertion, the first handshake may occur on the first rising edge with S_AXI_ARESETN=1.

Verification
REQ-027 Four writes with AW/W together: 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read all four.
- Reads return 0x1, 0x2, 0x3, 0x4 with RRESP=0.
- wr_pulse sequence is 0001, 0010, 0100, 1000.
REQ-028 Write 0xFFFFFFFF to 0x4, then write 0x12345678 to 0x4 with WSTRB=4'b0101, then read 0x4 -> 0xFF34FF78.
REQ-029 AW to 0x8 presented 3 cycles before W (0xA5A5A5A5).
- AWREADY is accepted immediately.
- BVALID rises 2 cycles after the W handshake.
- reg2_q = 0xA5A5A5A5.
REQ-030 Hold BREADY=0 for 5 cycles after a write, and present a second AW/W meanwhile.
- BVALID stays 1 throughout.
- AWREADY and WREADY stay 0 until the BREADY handshake.
- The second write then completes.
REQ-031 Write 0xDEADBEEF to 0xC, then read 0xC with RREADY held low for 4 cycles.
- RDATA holds 0xDEADBEEF and RVALID holds 1 for all 4 cycles.
- ARREADY stays 0 while the read is pending.
REQ-032 Assert S_AXI_ARESETN=0 after the AW handshake but before W.
- All outputs go to 0 immediately.
- No wr_pulse fires.
- After release, a read of 0x0 returns 0x0.
